// File: rtl/nibble_add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nibble_add_seq_pkg;

   localparam int unsigned NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Two's-complement overflow from the operand and result sign bits.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/adder_4.sv
// 4-bit carry-lookahead adder slice with group generate/propagate outputs.
module adder_4
   import nibble_add_seq_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] f,
   output logic             c3,
   output logic             gm,
   output logic             pm
);

   logic [NIB_W-1:0] g;
   logic [NIB_W-1:0] p;
   logic [NIB_W:0]   c;

   assign g = a & b;
   assign p = a ^ b;

   // Lookahead carries, each expanded directly from cin.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
   assign c[4] = gm | (pm & cin);

   assign gm = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   assign pm = &p;

   assign f  = p ^ c[NIB_W-1:0];
   assign c3 = c[4];

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit add/sub that reuses one 4-bit slice, LS nibble first.
module nibble_add_seq
   import nibble_add_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N     = WIDTH / NIB_W;
   localparam int unsigned IDX_W = $clog2(N);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [WIDTH-1:0]   a_r;
   logic [WIDTH-1:0]   b_r;
   logic [NIB_W-1:0]   nib_a;
   logic [NIB_W-1:0]   nib_b;
   logic [NIB_W-1:0]   f;
   logic               c3;
   logic               gm_unused;
   logic               pm_unused;
   logic               last;

   assign nib_a = a_r[NIB_W*idx +: NIB_W];
   assign nib_b = b_r[NIB_W*idx +: NIB_W];
   assign last  = (idx == IDX_W'(N - 1));

   adder_4 u_slice (
      .a   (nib_a),
      .b   (nib_b),
      .cin (carry),
      .f   (f),
      .c3  (c3),
      .gm  (gm_unused),
      .pm  (pm_unused)
   );

   // Controller, operand/carry registers and progressively written result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
         carry <= 1'b0;
         a_r   <= '0;
         b_r   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_r   <= a;
                  b_r   <= sub ? ~b : b;
                  carry <= sub;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               sum[NIB_W*idx +: NIB_W] <= f;
               carry                   <= c3;
               if (last) begin
                  idx   <= '0;
                  cout  <= c3;
                  ovf   <= signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], f[NIB_W-1]);
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq at WIDTH=16: vector table plus corner sequences.
module tb_nibble_add_seq;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned N     = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sub;
      logic [WIDTH-1:0] exp_sum;
      logic             exp_cout;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[9];

   nibble_add_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, " busy"}, 32'(busy), 32'd0);
      check({tag, " done"}, 32'(done), 32'd0);
      check({tag, " sum"},  32'(sum),  32'd0);
      check({tag, " cout"}, 32'(cout), 32'd0);
      check({tag, " ovf"},  32'(ovf),  32'd0);
   endtask

   // Issue one op, then wait (bounded) for done while counting busy cycles.
   task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vsub, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
      int busy_cnt;
      int lat;
      @(negedge clk);
      start = 1'b1; a = va; b = vb; sub = vsub;
      @(negedge clk);
      start = 1'b0;
      busy_cnt = 0;
      lat = 0;
      while (!done && lat < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles, required %0d", name, lat, N);
         return;
      end
      check({name, " latency"}, 32'(lat), 32'(N));
      check({name, " busy_cycles"}, 32'(busy_cnt), 32'(N));
      check({name, " busy_at_done"}, 32'(busy), 32'd0);
      check({name, " sum"}, 32'(sum), 32'(es));
      check({name, " cout"}, 32'(cout), 32'(ec));
      check({name, " ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      check({name, " done_pulse"}, 32'(done), 32'd0);
      check({name, " sum_hold"}, 32'(sum), 32'(es));
   endtask

   initial begin
      int done_cnt;

      vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;

      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);

      // Starts during RUN and DONE must be ignored.
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h4321; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 10 && !done; i++) @(negedge clk);
      check("ign done_seen", 32'(done), 32'd1);
      check("ign sum", 32'(sum), 32'h5555);
      if (done) done_cnt++;
      start = 1'b1; a = 16'h0F0F; b = 16'h0101; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (done) done_cnt++;
         @(negedge clk);
      end
      check("ign done_count", 32'(done_cnt), 32'd1);
      check("ign busy_after", 32'(busy), 32'd0);
      check("ign sum_after", 32'(sum), 32'h5555);
      check("ign cout_after", 32'(cout), 32'd0);

      // Reset asserted in the second RUN cycle aborts the op.
      start = 1'b1; a = 16'h0FFF; b = 16'h0001; sub = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle_zero("midrun_rst");
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) done_cnt++;
         @(negedge clk);
      end
      check("midrun_rst no_done", 32'(done_cnt), 32'd0);
      run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

      // Reset and start together: start is dropped.
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (done || busy) done_cnt++;
         @(negedge clk);
      end
      check("rst_start no_op", 32'(done_cnt), 32'd0);
      check("rst_start sum", 32'(sum), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
